// File: rtl/corelet_pkg.sv
// Shared types and sizing for the corelet datapath blocks.
// The PMEM arbiter takes its default widths and FSM encoding from here.
package corelet_pkg;

    localparam int PMEM_DATA_W = 128;
    localparam int PMEM_ADDR_W = 9;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_WR       = 2'd1,
        ARB_RD       = 2'd2,
        ARB_QUIESCED = 2'd3
    } pmem_arb_state_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick between the write and read requesters.
// The winner is the requester that did not go last, or the sole requester.
module arb_rr2 (
    input  logic wr_req,
    input  logic rd_req,
    input  logic last_rd,
    output logic pick_wr,
    output logic pick_rd
);

    always_comb begin
        pick_wr = wr_req & (~rd_req | last_rd);
        pick_rd = rd_req & (~wr_req | ~last_rd);
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares the single-port PMEM SRAM between the OFIFO write drain and the SFU read path,
// granting bounded bursts round-robin and supporting a quiesce/drain handshake.
module pmem_arbiter
    import corelet_pkg::*;
#(
    parameter int DATA_W = PMEM_DATA_W,
    parameter int ADDR_W = PMEM_ADDR_W,
    parameter int BURST  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              quiesce,
    output logic              idle,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] OP_q,
    output logic [DATA_W-1:0] OP_d,
    output logic [ADDR_W-1:0] OP_addr,
    output logic              OP_cen,
    output logic              OP_wen,
    output logic [1:0]        dbg_state
);

    // Handshake: a beat transfers in any cycle where req & gnt; the requester holds its
    // address/data stable until then. gnt is combinational and never asserted on both ports.

    localparam int CNT_W = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    pmem_arb_state_t   state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_rd_q, last_rd_d;
    logic              rd_valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] d_q;
    logic              arb_last_rd;
    logic              pick_wr, pick_rd;
    logic              arb_en;

    // Inside a burst the owner is favoured by pretending the other side went last;
    // once the burst is spent the owner is treated as last so the other side wins.
    always_comb begin
        arb_last_rd = last_rd_q;
        case (state_q)
            ARB_WR:  arb_last_rd = (cnt_q < BURST_C);
            ARB_RD:  arb_last_rd = ~(cnt_q < BURST_C);
            default: arb_last_rd = last_rd_q;
        endcase
    end

    arb_rr2 u_rr (
        .wr_req  (wr_req),
        .rd_req  (rd_req),
        .last_rd (arb_last_rd),
        .pick_wr (pick_wr),
        .pick_rd (pick_rd)
    );

    // Reset is folded in so grants (and hence SRAM strobes) drop the instant it asserts.
    assign arb_en = reset & ~quiesce & (state_q != ARB_QUIESCED);

    always_comb begin
        wr_gnt    = arb_en & pick_wr;
        rd_gnt    = arb_en & pick_rd;
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_rd_d = last_rd_q;
        if (quiesce) begin
            state_d = ARB_QUIESCED;
            cnt_d   = '0;
        end else if (state_q == ARB_QUIESCED) begin
            state_d = ARB_IDLE;
            cnt_d   = '0;
        end else if (wr_gnt) begin
            state_d   = ARB_WR;
            last_rd_d = 1'b0;
            cnt_d     = (state_q == ARB_WR && cnt_q < BURST_C) ? cnt_q + CNT_ONE : CNT_ONE;
        end else if (rd_gnt) begin
            state_d   = ARB_RD;
            last_rd_d = 1'b1;
            cnt_d     = (state_q == ARB_RD && cnt_q < BURST_C) ? cnt_q + CNT_ONE : CNT_ONE;
        end else begin
            state_d = ARB_IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        OP_cen  = 1'b1;
        OP_wen  = 1'b1;
        OP_addr = addr_q;
        OP_d    = d_q;
        if (wr_gnt) begin
            OP_cen  = 1'b0;
            OP_wen  = 1'b0;
            OP_addr = wr_addr;
            OP_d    = wr_data;
        end else if (rd_gnt) begin
            OP_cen  = 1'b0;
            OP_addr = rd_addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ARB_IDLE;
            cnt_q      <= '0;
            last_rd_q  <= 1'b1;
            rd_valid_q <= 1'b0;
            addr_q     <= '0;
            d_q        <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_rd_q  <= last_rd_d;
            rd_valid_q <= rd_gnt;
            addr_q     <= OP_addr;
            d_q        <= OP_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_data   = OP_q;
    assign idle      = (state_q == ARB_QUIESCED) & ~rd_valid_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: vector table plus hand sequences for reset, bursts,
// quiesce and read-after-write, against a 1-cycle-latency SRAM model.
module tb_pmem_arbiter;
    import corelet_pkg::*;

    localparam int DW = 128;
    localparam int AW = 9;
    localparam int BURST = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          quiesce = 1'b0;
    logic          idle;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_gnt;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_gnt;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] OP_q = '0;
    logic [DW-1:0] OP_d;
    logic [AW-1:0] OP_addr;
    logic          OP_cen;
    logic          OP_wen;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_err = 0;

    // clock / reset
    always #5 clk = ~clk;

    pmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .BURST(BURST)) dut (
        .clk(clk), .reset(reset), .quiesce(quiesce), .idle(idle),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .OP_q(OP_q), .OP_d(OP_d), .OP_addr(OP_addr), .OP_cen(OP_cen), .OP_wen(OP_wen),
        .dbg_state(dbg_state)
    );

    // SRAM model
    logic [DW-1:0] mem [0:511];
    logic [DW-1:0] ref_mem [0:511];
    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
    end
    always @(posedge clk) begin
        if (!OP_cen) begin
            if (!OP_wen) mem[OP_addr] <= OP_d;
            else         OP_q <= mem[OP_addr];
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard
    logic [DW-1:0] exp_q[$];
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
        end else begin
            if (rd_valid) begin
                if (exp_q.size() == 0) chk("rd_valid_unexpected", rd_valid, 1'b0);
                else chk("sb_rd_data", rd_data, exp_q.pop_front());
            end
            if (rd_gnt) exp_q.push_back(ref_mem[rd_addr]);
            if (wr_gnt) ref_mem[wr_addr] = wr_data;
        end
    end

    // driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic rd, input logic q, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [AW-1:0] ra);
        wr_req = wr; rd_req = rd; quiesce = q;
        wr_addr = wa; wr_data = wd; rd_addr = ra;
    endtask

    typedef struct {
        logic          wr, rd, q;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd;
        logic          ewg, erg, ecen, ewen, erv, eidle;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] ed;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic rd, input logic q,
                                input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic [AW-1:0] ra, input logic ewg, input logic erg,
                                input logic ecen, input logic ewen, input logic erv,
                                input logic eidle, input logic [AW-1:0] eaddr,
                                input logic [DW-1:0] ed);
        vec_t v;
        v.wr = wr; v.rd = rd; v.q = q; v.wa = wa; v.wd = wd; v.ra = ra;
        v.ewg = ewg; v.erg = erg; v.ecen = ecen; v.ewen = ewen; v.erv = erv;
        v.eidle = eidle; v.eaddr = eaddr; v.ed = ed;
        return v;
    endfunction

    vec_t vecs [13];
    logic [DW-1:0] a5;

    initial begin
        a5 = {16{8'hA5}};
        //             wr rd q  wa  wd      ra   wg rg cen wen rv idl addr d
        vecs[0]  = mk(1, 0, 0, 5, a5,     0,  1, 0, 0, 0, 0, 0, 5,  a5);
        vecs[1]  = mk(0, 0, 0, 6, 'h11,   0,  0, 0, 1, 1, 0, 0, 5,  a5);
        vecs[2]  = mk(0, 1, 0, 6, 'h11,   7,  0, 1, 0, 1, 0, 0, 7,  a5);
        vecs[3]  = mk(0, 0, 0, 6, 'h11,   7,  0, 0, 1, 1, 1, 0, 7,  a5);
        vecs[4]  = mk(1, 1, 0, 3, 'h33,   9,  1, 0, 0, 0, 0, 0, 3,  'h33);
        vecs[5]  = mk(0, 1, 0, 4, 'h44,   9,  0, 1, 0, 1, 0, 0, 9,  'h33);
        vecs[6]  = mk(1, 0, 0, 4, 'h44,   10, 1, 0, 0, 0, 1, 0, 4,  'h44);
        vecs[7]  = mk(0, 0, 0, 4, 'h44,   10, 0, 0, 1, 1, 0, 0, 4,  'h44);
        vecs[8]  = mk(1, 1, 0, 8, 'h88,   12, 0, 1, 0, 1, 0, 0, 12, 'h44);
        vecs[9]  = mk(1, 1, 1, 8, 'h88,   13, 0, 0, 1, 1, 1, 0, 12, 'h44);
        vecs[10] = mk(1, 0, 0, 8, 'h88,   13, 0, 0, 1, 1, 0, 1, 12, 'h44);
        vecs[11] = mk(1, 0, 0, 8, 'h88,   13, 1, 0, 0, 0, 0, 0, 8,  'h88);
        vecs[12] = mk(0, 0, 0, 8, 'h88,   13, 0, 0, 1, 1, 0, 0, 8,  'h88);

        // reset held with both requests pending
        drive(1, 1, 0, 3, 'h77, 4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_wr_gnt", wr_gnt, 1'b0);
            chk("rst_rd_gnt", rd_gnt, 1'b0);
            chk("rst_cen", OP_cen, 1'b1);
            chk("rst_wen", OP_wen, 1'b1);
            chk("rst_rd_valid", rd_valid, 1'b0);
            chk("rst_idle", idle, 1'b0);
            chk("rst_addr", OP_addr, '0);
        end
        next_cycle();
        reset = 1'b1;
        drive(0, 0, 0, 0, '0, 0);
        @(negedge clk);
        chk("post_rst_state", dbg_state, ARB_IDLE);

        // vector table
        for (int i = 0; i < 13; i++) begin
            next_cycle();
            drive(vecs[i].wr, vecs[i].rd, vecs[i].q, vecs[i].wa, vecs[i].wd, vecs[i].ra);
            @(negedge clk);
            chk($sformatf("v%0d_wr_gnt", i), wr_gnt, vecs[i].ewg);
            chk($sformatf("v%0d_rd_gnt", i), rd_gnt, vecs[i].erg);
            chk($sformatf("v%0d_cen", i), OP_cen, vecs[i].ecen);
            chk($sformatf("v%0d_wen", i), OP_wen, vecs[i].ewen);
            chk($sformatf("v%0d_addr", i), OP_addr, vecs[i].eaddr);
            chk($sformatf("v%0d_d", i), OP_d, vecs[i].ed);
            chk($sformatf("v%0d_rd_valid", i), rd_valid, vecs[i].erv);
            chk($sformatf("v%0d_idle", i), idle, vecs[i].eidle);
        end

        // write 5 then read it back
        next_cycle();
        drive(1, 0, 0, 5, 128'h1234, 0);
        @(negedge clk);
        chk("raw_wr_gnt", wr_gnt, 1'b1);
        next_cycle();
        drive(0, 1, 0, 0, '0, 5);
        @(negedge clk);
        chk("raw_rd_gnt", rd_gnt, 1'b1);
        chk("raw_rd_valid_early", rd_valid, 1'b0);
        next_cycle();
        drive(0, 0, 0, 0, '0, 5);
        @(negedge clk);
        chk("raw_rd_valid", rd_valid, 1'b1);
        chk("raw_rd_data", rd_data, 128'h1234);

        // both requesting: bursts of BURST alternate starting with write
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            drive(1, 1, 0, 20, DW'(i), 5);
            @(negedge clk);
            chk($sformatf("burst%0d_wr", i), wr_gnt, ((i / BURST) % 2 == 0));
            chk($sformatf("burst%0d_rd", i), rd_gnt, ((i / BURST) % 2 == 1));
            chk($sformatf("burst%0d_both", i), wr_gnt & rd_gnt, 1'b0);
        end

        // quiesce in the middle of a read burst
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            drive(0, 1, 0, 0, '0, 5);
            @(negedge clk);
            chk("q_pre_rd_gnt", rd_gnt, 1'b1);
        end
        next_cycle();
        drive(0, 1, 1, 0, '0, 5);
        @(negedge clk);
        chk("q_rd_gnt", rd_gnt, 1'b0);
        chk("q_wr_gnt", wr_gnt, 1'b0);
        chk("q_cen", OP_cen, 1'b1);
        chk("q_rd_valid_pending", rd_valid, 1'b1);
        chk("q_idle_first", idle, 1'b0);
        next_cycle();
        @(negedge clk);
        chk("q_idle", idle, 1'b1);
        chk("q_rd_valid_done", rd_valid, 1'b0);
        chk("q_hold_gnt", rd_gnt, 1'b0);
        next_cycle();
        quiesce = 1'b0;
        @(negedge clk);
        chk("q_exit_gnt", rd_gnt, 1'b0);
        chk("q_exit_idle", idle, 1'b1);
        next_cycle();
        @(negedge clk);
        chk("q_resume_gnt", rd_gnt, 1'b1);
        chk("q_resume_idle", idle, 1'b0);

        // reset right after a read grant drops the read
        wr_req = 1'b1;
        next_cycle();
        reset = 1'b0;
        #1;
        chk("mrst_rd_valid", rd_valid, 1'b0);
        chk("mrst_cen", OP_cen, 1'b1);
        chk("mrst_wr_gnt", wr_gnt, 1'b0);
        chk("mrst_rd_gnt", rd_gnt, 1'b0);
        chk("mrst_state", dbg_state, ARB_IDLE);
        next_cycle();
        @(negedge clk);
        chk("mrst_rd_valid_late", rd_valid, 1'b0);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("restart_wr_gnt", wr_gnt, 1'b1);
        chk("restart_rd_gnt", rd_gnt, 1'b0);
        next_cycle();
        drive(0, 0, 0, 0, '0, 0);
        @(negedge clk);
        chk("restart_state", dbg_state, ARB_WR);
        chk("restart_rd_valid", rd_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
